// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants, types and symbol function for the K=3 rate-1/2 convolutional code
//
// Purpose : generator polynomials, encoder state enum, code symbol type and
//           the symbol function shared by the encoder and the decoder tables.
// Contents: G1, G0, conv_state_t, conv_sym_t, SYM_ZERO, conv_sym().

package conv_pkg;

    // Generator taps ordered {u, s1, s0}; G1 drives symbol bit 1, G0 symbol bit 0.
    localparam logic [2:0] G1 = 3'b111;
    localparam logic [2:0] G0 = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENC  = 2'd1,
        ST_GAP  = 2'd2
    } conv_state_t;

    typedef logic [1:0] conv_sym_t;

    localparam conv_sym_t SYM_ZERO = 2'b00;

    function automatic conv_sym_t conv_sym(input logic u, input logic s1, input logic s0);
        logic [2:0] w_taps;
        w_taps = {u, s1, s0};
        return {^(w_taps & G1), ^(w_taps & G0)};
    endfunction

endpackage

// File: rtl/conv_encoder.sv
// rtl/conv_encoder.sv - byte-serial rate-1/2 K=3 convolutional encoder feeding the Viterbi decoder
//
// Purpose : accepts one PCM byte per valid/ready handshake, emits its eight
//           code symbols MSB first (one per clock) and then GAP_LEN zero
//           symbols so the decoder can finish its traceback.
// Ports   : clk        rising-edge clock
//           reset      asynchronous active-high reset
//           pcm_in     byte to encode, sampled on the acceptance edge
//           pcm_valid  upstream offers a byte
//           pcm_ready  encoder idle and able to accept
//           conv_code  registered code symbol {g1, g0}
//           busy       encoding or sending the gap
//           sync_err   one-cycle pulse: accepted byte has bit 7 = 0

module conv_encoder
    import conv_pkg::*;
#(
    parameter int GAP_LEN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pcm_in,
    input  logic       pcm_valid,
    output logic       pcm_ready,
    output logic [1:0] conv_code,
    output logic       busy,
    output logic       sync_err
);

    // The decoder needs 1 metric step plus 7 traceback steps after the last data symbol.
    generate
        if (GAP_LEN < 8) begin : g_gap_len_check
            $error("conv_encoder: GAP_LEN must be at least 8");
        end
    endgenerate

    localparam int              GW       = $clog2(GAP_LEN + 1);
    localparam logic [GW-1:0]   GAP_INIT = GW'(GAP_LEN);

    conv_state_t   r_state;
    logic [7:0]    r_byte;
    logic          r_s1;
    logic          r_s0;
    logic [2:0]    r_idx;
    logic [GW-1:0] r_gap;
    conv_sym_t     r_code;
    logic          r_sync_err;

    conv_state_t   w_state_next;
    logic [7:0]    w_byte_next;
    logic          w_s1_next;
    logic          w_s0_next;
    logic [2:0]    w_idx_next;
    logic [GW-1:0] w_gap_next;
    conv_sym_t     w_code_next;
    logic          w_sync_next;
    logic [2:0]    w_idx_dec;
    logic          w_bit;

    // r_idx names the bit already on the wire; ENC encodes the one below it.
    assign w_idx_dec = r_idx - 3'd1;
    assign w_bit     = r_byte[w_idx_dec];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_byte     <= 8'd0;
            r_s1       <= 1'b0;
            r_s0       <= 1'b0;
            r_idx      <= 3'd0;
            r_gap      <= '0;
            r_code     <= SYM_ZERO;
            r_sync_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_byte     <= w_byte_next;
            r_s1       <= w_s1_next;
            r_s0       <= w_s0_next;
            r_idx      <= w_idx_next;
            r_gap      <= w_gap_next;
            r_code     <= w_code_next;
            r_sync_err <= w_sync_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_byte_next  = r_byte;
        w_s1_next    = r_s1;
        w_s0_next    = r_s0;
        w_idx_next   = r_idx;
        w_gap_next   = r_gap;
        w_code_next  = SYM_ZERO;
        w_sync_next  = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (pcm_valid) begin
                    // Trellis restarts at 00 so bit 7 = 1 always opens with 11.
                    w_byte_next  = pcm_in;
                    w_idx_next   = 3'd7;
                    w_code_next  = conv_sym(pcm_in[7], 1'b0, 1'b0);
                    w_s1_next    = pcm_in[7];
                    w_s0_next    = 1'b0;
                    w_sync_next  = ~pcm_in[7];
                    w_state_next = ST_ENC;
                end
            end
            ST_ENC: begin
                w_code_next = conv_sym(w_bit, r_s1, r_s0);
                w_s1_next   = w_bit;
                w_s0_next   = r_s1;
                w_idx_next  = w_idx_dec;
                if (w_idx_dec == 3'd0) begin
                    w_gap_next   = GAP_INIT;
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                // Zero tail: also shifts zeros through the trellis.
                w_s1_next = 1'b0;
                w_s0_next = r_s1;
                if (r_gap == '0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_gap_next = r_gap - GW'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign pcm_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign conv_code = r_code;
    assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_conv_encoder.sv
// tb/tb_conv_encoder.sv - directed and randomised bench for conv_encoder
module tb_conv_encoder;

    localparam int GAP_LEN = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pcm_in;
    logic       pcm_valid;
    logic       pcm_ready;
    logic [1:0] conv_code;
    logic       busy;
    logic       sync_err;

    int         n_pass  = 0;
    int         n_total = 0;
    int         cyc     = 0;
    logic [1:0] sb_q[$];
    logic [15:0] cap;
    int         acc_cycle;

    conv_encoder #(.GAP_LEN(GAP_LEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .pcm_in    (pcm_in),
        .pcm_valid (pcm_valid),
        .pcm_ready (pcm_ready),
        .conv_code (conv_code),
        .busy      (busy),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Offer byte b at the current negedge; check every cycle until ready returns.
    task automatic run_byte(input logic [7:0] b, input bit hold);
        int       waited;
        logic     sa, sb, u;
        logic [1:0] exp_sym;
        pcm_in    = b;
        pcm_valid = 1'b1;
        waited    = 0;
        while (pcm_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_before_accept", {15'd0, pcm_ready}, 16'd1);
        acc_cycle = cyc;
        sa = 1'b0;
        sb = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            u = b[k];
            sb_q.push_back({u ^ sa ^ sb, u ^ sb});
            sb = sa;
            sa = u;
        end
        for (int k = 0; k < GAP_LEN; k++) sb_q.push_back(2'b00);
        @(negedge clk);
        if (!hold) pcm_valid = 1'b0;
        for (int i = 0; i < 8 + GAP_LEN; i++) begin
            if (i > 0) @(negedge clk);
            if (sb_q.size() == 0) begin
                chk("scoreboard_empty", 16'd1, 16'd0);
                exp_sym = 2'b00;
            end else begin
                exp_sym = sb_q.pop_front();
            end
            chk(i < 8 ? "data_symbol" : "gap_symbol", {14'd0, conv_code}, {14'd0, exp_sym});
            if (i < 8) cap[15 - 2*i -: 2] = conv_code;
            chk("busy_active", {15'd0, busy}, 16'd1);
            chk("ready_low_busy", {15'd0, pcm_ready}, 16'd0);
            chk("sync_err", {15'd0, sync_err}, {15'd0, (i == 0) ? ~b[7] : 1'b0});
        end
        @(negedge clk);
        chk("ready_return", {15'd0, pcm_ready}, 16'd1);
        chk("busy_end", {15'd0, busy}, 16'd0);
        chk("idle_code", {14'd0, conv_code}, 16'd0);
    endtask

    initial begin
        int         prev_acc;
        logic [7:0] b;
        logic [7:0] dec;

        reset     = 1'b1;
        pcm_in    = 8'h00;
        pcm_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_code", {14'd0, conv_code}, 16'd0);
        chk("rst_ready", {15'd0, pcm_ready}, 16'd1);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_sync", {15'd0, sync_err}, 16'd0);
        reset = 1'b0;
        @(negedge clk);

        run_byte(8'hA5, 1'b0);
        chk("a5_symbols", cap, 16'hE2F8);
        chk("a5_period", 16'(cyc - acc_cycle), 16'd17);
        run_byte(8'hFF, 1'b0);
        chk("ff_symbols", cap, 16'hDAAA);
        run_byte(8'h80, 1'b0);
        chk("80_symbols", cap, 16'hEC00);
        run_byte(8'h25, 1'b0);

        // Back-to-back with valid held high.
        run_byte(8'hC3, 1'b1);
        prev_acc = acc_cycle;
        run_byte(8'h9A, 1'b1);
        chk("b2b_spacing_1", 16'(acc_cycle - prev_acc), 16'd17);
        prev_acc = acc_cycle;
        run_byte(8'hE7, 1'b0);
        chk("b2b_spacing_2", 16'(acc_cycle - prev_acc), 16'd17);

        // Mid-byte asynchronous reset after the 4th symbol of 0xA5.
        pcm_in    = 8'hA5;
        pcm_valid = 1'b1;
        @(negedge clk);
        pcm_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_4th_symbol", {14'd0, conv_code}, 16'h2);
        #1 reset = 1'b1;
        #1;
        chk("abort_code", {14'd0, conv_code}, 16'd0);
        chk("abort_ready", {15'd0, pcm_ready}, 16'd1);
        chk("abort_busy", {15'd0, busy}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        @(negedge clk);
        run_byte(8'hFF, 1'b0);
        chk("post_abort_ff", cap, 16'hDAAA);

        // Random bytes with bit 7 = 1, recovered by inverting the g0 branch.
        for (int n = 0; n < 256; n++) begin
            b = {1'b1, 7'($urandom)};
            run_byte(b, 1'b0);
            for (int k = 7; k >= 0; k--)
                dec[k] = cap[2*k] ^ ((k <= 5) ? dec[k+2] : 1'b0);
            chk("loopback_byte", {8'd0, dec}, {8'd0, b});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/conv_encoder.md
# conv_encoder

- Rate-1/2, constraint-length-3 convolutional encoder; generators g1=111 (symbol bit 1) and g0=101 (symbol bit 0).
- Accepts one 8-bit PCM byte through a valid/ready handshake. Serializes it MSB-first into eight 2-bit code symbols, one per clock, then emits a fixed run of 00 gap symbols.
- Sits directly upstream of the Viterbi decoder and drives its `conv_code` input on the same clock.
- Each byte starts from the all-zero trellis state, so a byte with bit 7 = 1 always opens with symbol 11. The decoder uses that 11 as its frame-sync marker.

## Interface

**Parameters**
- GAP_LEN, default 8: number of 00 symbols sent after each byte. Values < 8 are illegal; they are rejected at elaboration. The decoder needs 8 cycles after the last data symbol: 1 metric step plus 7 traceback steps.

**Ports**
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- pcm_in  in  8  byte to encode; sampled only on the acceptance edge.
- pcm_valid  in  1  upstream has a byte on pcm_in.
- pcm_ready  out  1  encoder can accept; high only in IDLE.
- conv_code  out  2  registered code symbol to the decoder; {g1 output, g0 output}.
- busy  out  1  high in ENC and GAP.
- sync_err  out  1  one-cycle pulse: the accepted byte had bit 7 = 0, so the decoder will not sync on it.

## Operation

**States**
- IDLE: conv_code = 00, pcm_ready = 1.
  - On pcm_valid & pcm_ready at an edge: latch the byte, clear the shift register {s1,s0} to 00, load bit index = 7, go to ENC.
  - On that same edge, register the symbol for bit 7, so it appears on conv_code immediately.
- ENC: on each edge, register the symbol for the current bit and decrement the index.
  - Symbol computation for input bit u: conv_code <= {u^s1^s0, u^s0}; then s1 <= u, s0 <= s1.
  - After bit 0 has been registered, go to GAP with the gap counter = GAP_LEN.
- GAP: conv_code <= 00 each edge; decrement the counter; go to IDLE when it reaches 0.
  - The zero tail also flushes the trellis (K-1 = 2 symbols are enough).

**Encoding rules**
- Bits are taken MSB first.
- The byte is encoded as given, even when bit 7 = 0; in that case sync_err pulses in the cycle after acceptance.
- pcm_valid is ignored outside IDLE. A byte offered while busy is held by upstream and is not lost.
- The bit index is 3 bits and counts down 7..0 with no wrap. The gap counter is $clog2(GAP_LEN+1) bits.

**Reset** (asynchronous, any state, including mid-byte)
- Values: state = IDLE, conv_code = 00, {s1,s0} = 00, counters = 0, busy = 0, sync_err = 0, pcm_ready = 1.
- A partially sent byte is abandoned. The system resets the decoder together with the encoder.

## Timing

- Acceptance edge N: conv_code carries the bit-7 symbol during cycle N+1.
- Bit k's symbol is valid during cycle N+1+(7-k); the last data symbol is in cycle N+8.
- Gap symbols occupy cycles N+9 .. N+8+GAP_LEN. pcm_ready rises in cycle N+9+GAP_LEN.
- Minimum byte period is 9+GAP_LEN cycles; 17 at the default.
- busy is high exactly in cycles N+1 .. N+8+GAP_LEN.
- pcm_ready is combinational from the state register. pcm_valid may be held high continuously.

## Structure

**Shared package `conv_pkg`**
- Generator constants G1 = 3'b111 and G0 = 3'b101.
- Enum for the IDLE/ENC/GAP states.
- 2-bit symbol typedef.
- Function conv_sym(u, s1, s0) returning the 2-bit symbol.
- The decoder's branch-metric tables are derived from the same constants.

**Sub-modules**
- None. This is one FSM plus a datapath; the symbol logic lives in the package function.

## Test plan

- Reset, then 0xA5 with valid → conv_code 11,10,00,10,11,11,10,00; then eight 00; sync_err stays 0; ready returns in cycle 18.
- 0xFF → 11,01,10,10,10,10,10,10. 0x80 → 11,10,11,00,00,00,00,00.
- 0x25 (bit 7 = 0) → first symbol 00; sync_err pulses for exactly one cycle after acceptance; byte fully encoded.
- pcm_valid held high over 3 bytes → acceptances exactly 17 cycles apart; no symbol 11 anywhere in the gaps.
- Reset asserted after the 4th symbol of 0xA5 → conv_code = 00 and ready = 1 immediately (asynchronously). The next byte 0xFF encodes exactly as from reset.
- Loopback: encoder into decoder for 256 random bytes with bit 7 = 1 → every decoded pcm equals the sent byte.
